// File: rtl/mmp_iddmm_drv_if.sv
// Load, multiplier and result-stream signals of the IDDMM driver.
// The driver takes the slave side; the environment takes the master side.
interface mmp_iddmm_drv_if #(
  parameter int unsigned K      = 128,
  parameter int unsigned N      = 16,
  parameter int unsigned ADDR_W = $clog2(N)
);
  logic [K-1:0]      cfg_m1;
  logic              in_valid;
  logic              in_ready;
  logic [K-1:0]      in_x;
  logic [K-1:0]      in_y;
  logic [1:0]        wr_ena;
  logic [ADDR_W-1:0] wr_addr;
  logic [K-1:0]      wr_x;
  logic [K-1:0]      wr_y;
  logic [K-1:0]      wr_m;
  logic [K-1:0]      wr_m1;
  logic              task_req;
  logic              task_grant;
  logic [K-1:0]      task_res;
  logic              task_end;
  logic              out_valid;
  logic              out_ready;
  logic [K-1:0]      out_data;
  logic              out_last;
  logic              busy;
  logic [1:0]        err;

  modport slave (
    input  cfg_m1, in_valid, in_x, in_y, task_grant, task_res, task_end, out_ready,
    output in_ready, wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1, task_req,
           out_valid, out_data, out_last, busy, err
  );

  modport master (
    output cfg_m1, in_valid, in_x, in_y, task_grant, task_res, task_end, out_ready,
    input  in_ready, wr_ena, wr_addr, wr_x, wr_y, wr_m, wr_m1, task_req,
           out_valid, out_data, out_last, busy, err
  );
endinterface

// File: rtl/mmp_iddmm_drv.sv
// Driver for an IDDMM Montgomery multiplier: loads x/y words, starts the task,
// buffers the result words in a first-word-fall-through FIFO and streams them out.
module mmp_iddmm_drv #(
  parameter int unsigned K       = 128,
  parameter int unsigned N       = 16,
  parameter int unsigned ADDR_W  = $clog2(N),
  parameter int unsigned TIMEOUT = 4096
) (
  input logic            clk,
  input logic            rst,
  mmp_iddmm_drv_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(N + 2);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, REQ, RUN, DRAIN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d, wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, gcnt_q, gcnt_d, pcnt_q, pcnt_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [K-1:0]      mem_q [N];
  logic [K-1:0]      wr_x_q, wr_x_d, wr_y_q, wr_y_d, wr_m1_q, wr_m1_d;
  logic [K-1:0]      out_data_q, out_data_d;
  logic [1:0]        wr_ena_q, wr_ena_d, err_q, err_d;
  logic              in_ready_q, in_ready_d, busy_q, busy_d, task_req_q, task_req_d;
  logic              out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic              accept, push, pop, full;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(N - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

  // Counters saturate one past N so excess grants/pops can never wrap back to a legal value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(N + 1)) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    gcnt_d     = gcnt_q;
    pcnt_d     = pcnt_q;
    tmo_d      = tmo_q;
    wr_addr_d  = wr_addr_q;
    wr_x_d     = wr_x_q;
    wr_y_d     = wr_y_q;
    wr_m1_d    = wr_m1_q;
    err_d      = err_q;
    wr_ena_d   = 2'b00;
    task_req_d = 1'b0;
    accept     = bus.in_valid & in_ready_q;
    pop        = out_valid_q & bus.out_ready;
    full       = (cnt_q == CNT_W'(N));
    push       = 1'b0;

    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
      pcnt_d   = sat_inc(pcnt_q);
    end

    unique case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          if (state_q == IDLE) begin
            err_d   = 2'b00;
            wr_m1_d = bus.cfg_m1;
            gcnt_d  = '0;
          end
          wr_ena_d  = 2'b11;
          wr_addr_d = idx_q;
          wr_x_d    = bus.in_x;
          wr_y_d    = bus.in_y;
          if (idx_q == ADDR_W'(N - 1)) begin
            idx_d   = '0;
            state_d = REQ;
          end else begin
            idx_d   = idx_q + ADDR_W'(1);
            state_d = LOAD;
          end
        end
      end
      REQ: begin
        task_req_d = 1'b1;
        tmo_d      = '0;
        state_d    = RUN;
      end
      RUN: begin
        if (bus.task_grant) begin
          if (full) begin
            err_d[0] = 1'b1;
          end else begin
            push   = 1'b1;
            gcnt_d = sat_inc(gcnt_q);
          end
        end
        // A grant in the same cycle as task_end is already included in gcnt_d.
        if (bus.task_end) begin
          if (gcnt_d != CNT_W'(N)) err_d[0] = 1'b1;
          state_d = DRAIN;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          err_d[1] = 1'b1;
          state_d  = DRAIN;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          pcnt_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
    cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

    in_ready_d  = (state_d == IDLE) || (state_d == LOAD);
    busy_d      = (state_d != IDLE);
    out_valid_d = (cnt_d != '0);
    out_last_d  = (cnt_d != '0) && (pcnt_d == CNT_W'(N - 1));
    // Next head is either stored already or is the word being pushed right now.
    out_data_d  = (push && (wr_ptr_q == rd_ptr_d)) ? bus.task_res : mem_q[rd_ptr_d];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      gcnt_q      <= '0;
      pcnt_q      <= '0;
      tmo_q       <= '0;
      wr_addr_q   <= '0;
      wr_x_q      <= '0;
      wr_y_q      <= '0;
      wr_m1_q     <= '0;
      out_data_q  <= '0;
      wr_ena_q    <= 2'b00;
      err_q       <= 2'b00;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      task_req_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      gcnt_q      <= gcnt_d;
      pcnt_q      <= pcnt_d;
      tmo_q       <= tmo_d;
      wr_addr_q   <= wr_addr_d;
      wr_x_q      <= wr_x_d;
      wr_y_q      <= wr_y_d;
      wr_m1_q     <= wr_m1_d;
      out_data_q  <= out_data_d;
      wr_ena_q    <= wr_ena_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      task_req_q  <= task_req_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.task_res;
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.wr_ena    = wr_ena_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_x      = wr_x_q;
  assign bus.wr_y      = wr_y_q;
  assign bus.wr_m      = '0;
  assign bus.wr_m1     = wr_m1_q;
  assign bus.task_req  = task_req_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_mmp_iddmm_drv.sv
// Randomized and directed bench for mmp_iddmm_drv, checked every cycle against
// a transaction-level model (phase + result queue) plus literal expectations.
`timescale 1ns/1ps
module tb_mmp_iddmm_drv;
  localparam int unsigned K   = 128;
  localparam int unsigned N   = 16;
  localparam int unsigned TMO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mmp_iddmm_drv_if #(.K(K), .N(N)) bus ();
  mmp_iddmm_drv #(.K(K), .N(N), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int omode = 0;
  bit chk_en = 1'b0;

  // Model: phase 0 idle, 1 loading, 2 start pending, 3 multiplier running, 4 draining.
  int         m_ph, m_idx, m_g, m_p, m_t;
  logic [K-1:0] mq [$];
  logic [1:0] e_err, e_wr_ena;
  logic [3:0] e_addr;
  logic [K-1:0] e_x, e_y, e_m1;
  bit         e_req;

  logic [K-1:0] cap [$];
  bit           capl [$];
  int           wa [$];
  int           wc [$];
  int           treq_cyc, treq_n, err1_cyc;
  bit           err1_seen;

  task automatic chk(input string nm, input logic [K-1:0] act, input logic [K-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_vec++;
    n_bad++;
    $display("FAIL %s: wait bound expired (cycle %0d)", nm, cyc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model, advanced on every clock edge with the inputs the DUT sees.
  initial forever begin
    int occ;
    bit acc, pop;
    @(posedge clk);
    if (rst) begin
      m_ph = 0; m_idx = 0; m_g = 0; m_p = 0; m_t = 0;
      mq.delete();
      e_err = '0; e_wr_ena = '0; e_addr = '0; e_x = '0; e_y = '0; e_m1 = '0; e_req = 0;
      chk_en = 1'b1;
    end else begin
      occ = mq.size();
      acc = bus.in_valid && (m_ph <= 1);
      pop = (occ != 0) && bus.out_ready;
      e_wr_ena = 2'b00;
      e_req    = 1'b0;
      if (pop) begin
        void'(mq.pop_front());
        m_p++;
      end
      case (m_ph)
        0, 1: if (acc) begin
          if (m_ph == 0) begin e_err = 2'b00; e_m1 = bus.cfg_m1; m_g = 0; end
          e_wr_ena = 2'b11; e_addr = 4'(m_idx); e_x = bus.in_x; e_y = bus.in_y;
          if (m_idx == N - 1) begin m_idx = 0; m_ph = 2; end
          else begin m_idx++; m_ph = 1; end
        end
        2: begin e_req = 1'b1; m_t = 0; m_ph = 3; end
        3: begin
          if (bus.task_grant) begin
            if (occ == N) e_err[0] = 1'b1;
            else begin mq.push_back(bus.task_res); m_g++; end
          end
          if (bus.task_end) begin
            if (m_g != N) e_err[0] = 1'b1;
            m_ph = 4;
          end else if (m_t == TMO - 1) begin
            e_err[1] = 1'b1;
            m_ph = 4;
          end else m_t++;
        end
        4: if (occ == 0) begin m_ph = 0; m_p = 0; end
        default: m_ph = 0;
      endcase
    end
  end

  // Compare process and observers, on the falling edge.
  initial forever begin
    bit ev;
    @(negedge clk);
    if (chk_en) begin
      ev = (mq.size() != 0);
      chk("in_ready",  K'(bus.in_ready),  K'(m_ph <= 1));
      chk("busy",      K'(bus.busy),      K'(m_ph != 0));
      chk("wr_ena",    K'(bus.wr_ena),    K'(e_wr_ena));
      chk("wr_addr",   K'(bus.wr_addr),   K'(e_addr));
      chk("wr_x",      bus.wr_x,          e_x);
      chk("wr_y",      bus.wr_y,          e_y);
      chk("wr_m",      bus.wr_m,          '0);
      chk("wr_m1",     bus.wr_m1,         e_m1);
      chk("task_req",  K'(bus.task_req),  K'(e_req));
      chk("err",       K'(bus.err),       K'(e_err));
      chk("out_valid", K'(bus.out_valid), K'(ev));
      chk("out_last",  K'(bus.out_last),  K'(ev && (m_p == N - 1)));
      if (ev) chk("out_data", bus.out_data, mq[0]);
    end
    if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      cap.push_back(bus.out_data);
      capl.push_back(bus.out_last);
    end
    if (bus.wr_ena === 2'b11) begin wa.push_back(int'(bus.wr_addr)); wc.push_back(cyc); end
    if (bus.task_req === 1'b1) begin treq_cyc = cyc; treq_n++; end
    if (bus.err[1] === 1'b1 && !err1_seen) begin err1_seen = 1'b1; err1_cyc = cyc; end
  end

  // out_ready patterns: 0 always, 1 held low, 2 one cycle in three, 3 random.
  initial begin
    int k = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      k++;
      case (omode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = 1'b0;
        2: bus.out_ready = (k % 3 == 0);
        default: bus.out_ready = 1'($urandom_range(1));
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic load(input int bx, input int by, input bit gaps);
    for (int i = 0; i < N; i++) begin
      int w = 0;
      if (gaps) while ($urandom_range(3) == 0) begin bus.in_valid = 1'b0; tick(); end
      bus.in_valid = 1'b1;
      bus.in_x     = K'(bx + i);
      bus.in_y     = K'(by + i);
      bus.cfg_m1   = {4{$urandom}};
      while (!bus.in_ready && w < 200) begin tick(); w++; end
      if (w >= 200) bound_fail("load_ready");
      tick();
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_treq();
    int w = 0;
    while (!bus.task_req && w < 50) begin tick(); w++; end
    if (w >= 50) bound_fail("task_req_wait");
  endtask

  task automatic grant_one(input logic [K-1:0] res, input bit with_end);
    bus.task_grant = 1'b1;
    bus.task_res   = res;
    bus.task_end   = with_end;
    tick();
    bus.task_grant = 1'b0;
    bus.task_end   = 1'b0;
  endtask

  task automatic mult(input int ngr, input bit do_end, input int base, input bit gaps, input bit comb);
    wait_treq();
    for (int g = 0; g < ngr; g++) begin
      if (gaps) while ($urandom_range(2) == 0) tick();
      grant_one(K'(base + g), comb && do_end && (g == ngr - 1));
    end
    if (do_end && !(comb && ngr > 0)) begin
      bus.task_end = 1'b1;
      tick();
      bus.task_end = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    while ((bus.busy || bus.out_valid) && w < 2000) begin tick(); w++; end
    if (w >= 2000) bound_fail("idle_wait");
    tick();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_x = '0; bus.in_y = '0; bus.cfg_m1 = '0;
    bus.task_grant = 1'b0; bus.task_res = '0; bus.task_end = 1'b0;
    treq_n = 0; err1_seen = 1'b0;
    tick(); tick(); tick();
    rst = 1'b0;
    chk("rst_in_ready", K'(bus.in_ready), K'(1));
    chk("rst_busy",     K'(bus.busy),     K'(0));
    chk("rst_err",      K'(bus.err),      K'(0));
    chk("rst_valid",    K'(bus.out_valid), K'(0));

    // Back-to-back load, full-rate drain.
    omode = 0; cap.delete(); capl.delete(); wa.delete(); wc.delete(); treq_n = 0;
    load(0, 16, 1'b0);
    chk("load_busy", K'(bus.busy), K'(1));
    mult(16, 1'b1, 100, 1'b0, 1'b0);
    wait_idle();
    chk("wr_count", K'(wa.size()), K'(16));
    for (int i = 0; i < 16 && i < wa.size(); i++) begin
      chk("wr_addr_seq", K'(wa[i]), K'(i));
      chk("wr_cycle_seq", K'(wc[i] - wc[0]), K'(i));
    end
    chk("treq_count", K'(treq_n), K'(1));
    if (wc.size() == 16) chk("treq_timing", K'(treq_cyc - wc[15]), K'(1));
    chk("res_count", K'(cap.size()), K'(16));
    for (int i = 0; i < 16 && i < cap.size(); i++) begin
      chk("res_data", cap[i], K'(100 + i));
      chk("res_last", K'(capl[i]), K'(i == 15));
    end
    chk("res_err", K'(bus.err), K'(0));
    chk("res_busy", K'(bus.busy), K'(0));

    // Hold the stream until the FIFO is full, then release slowly.
    omode = 1; cap.delete(); capl.delete();
    load(200, 300, 1'b0);
    mult(16, 1'b1, 500, 1'b0, 1'b0);
    chk("full_none_out", K'(cap.size()), K'(0));
    chk("full_valid", K'(bus.out_valid), K'(1));
    omode = 2;
    wait_idle();
    chk("slow_count", K'(cap.size()), K'(16));
    for (int i = 0; i < 16 && i < cap.size(); i++) chk("slow_data", cap[i], K'(500 + i));
    chk("slow_err", K'(bus.err), K'(0));

    // Seventeenth grant into a full FIFO.
    omode = 1; cap.delete(); capl.delete();
    load(1, 2, 1'b0);
    mult(17, 1'b1, 700, 1'b0, 1'b0);
    omode = 0;
    wait_idle();
    chk("ovf_count", K'(cap.size()), K'(16));
    if (cap.size() == 16) chk("ovf_last_word", cap[15], K'(715));
    chk("ovf_err", K'(bus.err), K'(1));

    // Timeout: no task_end.
    cap.delete(); capl.delete();
    load(3, 4, 1'b0);
    chk("err_cleared", K'(bus.err), K'(0));
    err1_seen = 1'b0;
    mult(16, 1'b0, 800, 1'b0, 1'b0);
    wait_idle();
    chk("tmo_seen", K'(err1_seen), K'(1));
    chk("tmo_timing", K'(err1_cyc - treq_cyc), K'(64));
    chk("tmo_err", K'(bus.err), K'(2));
    chk("tmo_count", K'(cap.size()), K'(16));

    // Reset mid-task after five grants.
    load(5, 6, 1'b0);
    wait_treq();
    for (int g = 0; g < 5; g++) grant_one(K'(50 + g), 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_in_ready", K'(bus.in_ready), K'(1));
    chk("mrst_busy",     K'(bus.busy),     K'(0));
    chk("mrst_valid",    K'(bus.out_valid), K'(0));
    chk("mrst_wr_ena",   K'(bus.wr_ena),   K'(0));
    chk("mrst_wr_x",     bus.wr_x,         '0);
    chk("mrst_wr_m1",    bus.wr_m1,        '0);
    chk("mrst_err",      K'(bus.err),      K'(0));
    cap.delete(); capl.delete();
    for (int g = 5; g < 16; g++) grant_one(K'(50 + g), 1'b0);
    bus.task_end = 1'b1; tick(); bus.task_end = 1'b0;
    tick(); tick();
    chk("mrst_no_out", K'(cap.size()), K'(0));
    chk("mrst_idle", K'(bus.busy), K'(0));
    load(7, 8, 1'b0);
    mult(16, 1'b1, 900, 1'b0, 1'b0);
    wait_idle();
    chk("post_rst_count", K'(cap.size()), K'(16));
    if (cap.size() > 0) chk("post_rst_first", cap[0], K'(900));

    // Randomized tasks: gaps, back-pressure, grant counts 15..17, missing/merged task_end.
    omode = 3;
    for (int t = 0; t < 12; t++) begin
      int ngr;
      bit de, cb;
      ngr = 15 + $urandom_range(2);
      de  = ($urandom_range(9) != 0);
      cb  = 1'($urandom_range(1));
      load($urandom_range(10000), $urandom_range(10000), 1'b1);
      mult(ngr, de, $urandom_range(100000), 1'b1, cb);
      wait_idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
